alu_cmd_sequencer: RTL and testbench

Command front-end for the combinational ALU. It accepts operand/opcode commands over a valid/ready handshake and holds them stable on the ALU inputs for a programmable settle time. It then captures the ALU's 2n-bit result into a small result FIFO that downstream logic drains with its own valid/ready handshake. The block sits directly upstream of the ALU and owns its x/y/op inputs; the ALU's f output comes back into this block.

---
 rtl/alu_pkg.sv | 11 +
 rtl/alu_result_fifo.sv | 67 ++++++
 rtl/alu_cmd_sequencer.sv | 111 +++++++++++
 tb/tb_alu_cmd_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command front-end.
// Imported by the sequencer and its result FIFO.
package alu_pkg;
  localparam int ALU_OP_W = 3;
  localparam int N_DEF    = 16;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;
endpackage

// File: rtl/alu_result_fifo.sv
// Small circular FIFO holding {op, result} entries for the consumer.
// Head data reads as zero whenever the FIFO is empty.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter  int W     = 2 * N_DEF + ALU_OP_W,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          empty,
  output logic [LW-1:0] level
);
  localparam logic [LW-1:0] FULL_L = LW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic          do_push;
  logic          do_pop;
  logic          full;

  assign full    = (lvl_q == FULL_L);
  assign empty   = (lvl_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   lvl_d = lvl_q + 1'b1;
      2'b01:   lvl_d = lvl_q - 1'b1;
      default: lvl_d = lvl_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

  // Storage needs no reset: the level gates what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

  assign pop_data = empty ? '0 : mem_q[rd_q];
  assign level    = lvl_q;
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Holds ALU operands stable for a settle time, then queues the result.
// One command in flight; results drained through a small FIFO.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter  int n      = N_DEF,
  parameter  int SETTLE = 1,
  parameter  int DEPTH  = 4,
  localparam int LW     = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [n-1:0]        in_x,
  input  logic [n-1:0]        in_y,
  input  logic [ALU_OP_W-1:0] in_op,
  output logic [n-1:0]        alu_x,
  output logic [n-1:0]        alu_y,
  output logic [ALU_OP_W-1:0] alu_op,
  input  logic [2*n-1:0]      alu_f,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*n-1:0]      out_f,
  output logic [ALU_OP_W-1:0] out_op,
  output logic                busy,
  output logic [LW-1:0]       level
);
  localparam int            FW      = 2 * n + ALU_OP_W;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [n-1:0]          x_q, x_d;
  logic [n-1:0]          y_q, y_d;
  logic [ALU_OP_W-1:0]   op_q, op_d;
  logic                  rdy;
  logic                  push;
  logic                  fifo_empty;
  logic [FW-1:0]         head;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    op_d    = op_q;
    rdy     = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        rdy = rst_n && (level < DEPTH_L);
        if (in_valid && rdy) begin
          x_d     = in_x;
          y_d     = in_y;
          op_d    = in_op;
          cnt_d   = 4'(SETTLE);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          push    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      op_q    <= op_d;
    end
  end

  alu_result_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({op_q, alu_f}),
    .pop       (out_ready),
    .pop_data  (head),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign in_ready  = rdy;
  assign alu_x     = x_q;
  assign alu_y     = y_q;
  assign alu_op    = op_q;
  assign out_valid = !fifo_empty;
  assign out_f     = head[2*n-1:0];
  assign out_op    = head[FW-1 -: ALU_OP_W];
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: three instances cover
// settle times of 1, 0 and 3 cycles.
module tb_alu_cmd_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] dx, dy;
  logic [2:0]  dop;

  // instance A: SETTLE=1, DEPTH=4
  logic va, rdy_a, ov_a, ordy_a, busy_a;
  logic [15:0] ax_a, ay_a;
  logic [2:0]  aop_a, oop_a, lvl_a;
  logic [31:0] f_a, of_a;
  // instance B: SETTLE=0
  logic vb, rdy_b, ov_b, ordy_b, busy_b;
  logic [15:0] ax_b, ay_b;
  logic [2:0]  aop_b, oop_b, lvl_b;
  logic [31:0] f_b, of_b;
  // instance C: SETTLE=3, alu_f driven directly
  logic vc, rdy_c, ov_c, ordy_c, busy_c;
  logic [15:0] ax_c, ay_c;
  logic [2:0]  aop_c, oop_c, lvl_c;
  logic [31:0] f_c, of_c;

  function automatic logic [31:0] alu_model(
    input logic [15:0] x, input logic [15:0] y, input logic [2:0] op);
    case (op)
      3'd0:    return 32'(x) + 32'(y);
      3'd1:    return {16'h0, 16'(x - y)};
      3'd2:    return 32'(x) * 32'(y);
      default: return {x, y};
    endcase
  endfunction

  assign f_a = alu_model(ax_a, ay_a, aop_a);
  assign f_b = alu_model(ax_b, ay_b, aop_b);

  alu_cmd_sequencer #(.n(16), .SETTLE(1), .DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(va), .in_ready(rdy_a),
    .in_x(dx), .in_y(dy), .in_op(dop),
    .alu_x(ax_a), .alu_y(ay_a), .alu_op(aop_a), .alu_f(f_a),
    .out_valid(ov_a), .out_ready(ordy_a), .out_f(of_a),
    .out_op(oop_a), .busy(busy_a), .level(lvl_a));

  alu_cmd_sequencer #(.n(16), .SETTLE(0), .DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_ready(rdy_b),
    .in_x(dx), .in_y(dy), .in_op(dop),
    .alu_x(ax_b), .alu_y(ay_b), .alu_op(aop_b), .alu_f(f_b),
    .out_valid(ov_b), .out_ready(ordy_b), .out_f(of_b),
    .out_op(oop_b), .busy(busy_b), .level(lvl_b));

  alu_cmd_sequencer #(.n(16), .SETTLE(3), .DEPTH(4)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(vc), .in_ready(rdy_c),
    .in_x(dx), .in_y(dy), .in_op(dop),
    .alu_x(ax_c), .alu_y(ay_c), .alu_op(aop_c), .alu_f(f_c),
    .out_valid(ov_c), .out_ready(ordy_c), .out_f(of_c),
    .out_op(oop_c), .busy(busy_c), .level(lvl_c));

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [15:0] x, input logic [15:0] y,
                        input logic [2:0] op, input int budget,
                        output bit ok);
    ok  = 1'b0;
    dx  = x;
    dy  = y;
    dop = op;
    va  = 1'b1;
    for (int i = 0; i < budget && !ok; i++) begin
      if (rdy_a) ok = 1'b1;
      step();
    end
    va = 1'b0;
  endtask

  // stream monitor
  bit mon_en = 1'b0;
  int max_lvl = 0;
  logic [34:0] got_q[$];
  always @(negedge clk) begin
    if (mon_en) begin
      if (int'(lvl_a) > max_lvl) max_lvl = int'(lvl_a);
      if (ov_a && ordy_a) got_q.push_back({oop_a, of_a});
    end
  end

  initial begin
    bit ok;
    int acc;
    logic [34:0] exp_e, got_e;
    va = 0; vb = 0; vc = 0;
    ordy_a = 0; ordy_b = 0; ordy_c = 0;
    dx = 0; dy = 0; dop = 0; f_c = 0;

    step();
    step();
    chk("rst_rdy", rdy_a, 0);
    chk("rst_ov", ov_a, 0);
    chk("rst_lvl", lvl_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_ax", ax_a, 0);
    chk("rst_of", of_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("idle_rdy", rdy_a, 1);

    // basic: x=5 y=7 op=0, SETTLE=1
    dx = 16'd5; dy = 16'd7; dop = 3'd0; va = 1'b1;
    step();
    va = 1'b0;
    chk("t1_ax", ax_a, 5);
    chk("t1_ay", ay_a, 7);
    chk("t1_busy", busy_a, 1);
    chk("t1_rdy0", rdy_a, 0);
    step();
    chk("t1_ov_e1", ov_a, 0);
    step();
    chk("t1_ov_e2", ov_a, 1);
    chk("t1_of", of_a, 32'h0000_000C);
    chk("t1_oop", oop_a, 0);
    chk("t1_rdy1", rdy_a, 1);
    chk("t1_lvl", lvl_a, 1);
    ordy_a = 1'b1;
    step();
    ordy_a = 1'b0;
    chk("t1_pop_ov", ov_a, 0);
    chk("t1_pop_lvl", lvl_a, 0);

    // SETTLE=0: x=8 y=2 op=1
    dx = 16'd8; dy = 16'd2; dop = 3'd1;
    chk("t2_rdy", rdy_b, 1);
    vb = 1'b1;
    step();
    vb = 1'b0;
    chk("t2_ov_e0", ov_b, 0);
    chk("t2_busy", busy_b, 1);
    step();
    chk("t2_ov_e1", ov_b, 1);
    chk("t2_of", of_b, 32'd6);
    chk("t2_oop", oop_b, 1);

    // SETTLE=3: only alu_f at E4 is captured
    dx = 16'd1; dy = 16'd2; dop = 3'd5;
    f_c = 32'h111;
    vc = 1'b1;
    step();
    vc = 1'b0;
    f_c = 32'h222;
    step();
    f_c = 32'h333;
    step();
    f_c = 32'h444;
    step();
    chk("t3_ov_e3", ov_c, 0);
    f_c = 32'h555;
    step();
    chk("t3_ov_e4", ov_c, 1);
    chk("t3_of", of_c, 32'h555);
    chk("t3_oop", oop_c, 5);
    f_c = 32'h666;
    step();
    chk("t3_hold", of_c, 32'h555);

    // fill: 5 commands, out_ready low
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      send_a(16'(i + 1), 16'd10, 3'(i), 10, ok);
      if (ok) acc++;
    end
    chk("t4_acc", acc, 4);
    chk("t4_lvl", lvl_a, 4);
    chk("t4_rdy", rdy_a, 0);
    ordy_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_ov", ov_a, 1);
      chk("t4_of", of_a, alu_model(16'(i + 1), 16'd10, 3'(i)));
      chk("t4_oop", oop_a, i);
      step();
      if (i == 0) begin
        chk("t4_lvl3", lvl_a, 3);
        chk("t4_rdy3", rdy_a, 1);
      end
    end
    ordy_a = 1'b0;
    chk("t4_empty", ov_a, 0);
    chk("t4_lvl0", lvl_a, 0);

    // streaming with out_ready held high
    ordy_a = 1'b1;
    max_lvl = 0;
    mon_en = 1'b1;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      send_a(16'(3 * i + 1), 16'(i + 2), 3'(i), 20, ok);
      if (ok) acc++;
    end
    repeat (5) step();
    mon_en = 1'b0;
    chk("t5_acc", acc, 10);
    chk("t5_cnt", got_q.size(), 10);
    chk("t5_maxlvl", max_lvl <= 1, 1);
    for (int i = 0; i < 10; i++) begin
      exp_e = {3'(i), alu_model(16'(3 * i + 1), 16'(i + 2), 3'(i))};
      got_e = (i < got_q.size()) ? got_q[i] : '0;
      chk("t5_ent", got_e, exp_e);
    end
    ordy_a = 1'b0;

    // async reset mid-WAIT with 2 queued
    send_a(16'd1, 16'd1, 3'd0, 10, ok);
    send_a(16'd2, 16'd2, 3'd1, 10, ok);
    send_a(16'd3, 16'd3, 3'd2, 10, ok);
    chk("t6_lvl2", lvl_a, 2);
    chk("t6_busy", busy_a, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_ov", ov_a, 0);
    chk("t6_lvl", lvl_a, 0);
    chk("t6_busy0", busy_a, 0);
    chk("t6_rdy", rdy_a, 0);
    chk("t6_ax", ax_a, 0);
    chk("t6_of", of_a, 0);
    chk("t6_oop", oop_a, 0);
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t6_rdy1", rdy_a, 1);
    chk("t6_lvl_r", lvl_a, 0);
    repeat (4) step();
    chk("t6_nostale", ov_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
